// File: rtl/pcs_40g_rx_am_lock_pkg.sv
// Shared 40GBASE-R alignment-marker definitions, used by both the RX lock
// and the TX marker inserter.
package pcs_40g_pkg;

    localparam int         LANE_N  = 4;
    localparam logic [1:0] AM_SYNC = 2'b10;

    typedef struct packed {
        logic [7:0] m0;
        logic [7:0] m1;
        logic [7:0] m2;
    } am_lane_t;

    localparam am_lane_t AM_LANE [LANE_N] = '{
        '{m0: 8'h90, m1: 8'h76, m2: 8'h47},
        '{m0: 8'hF0, m1: 8'hC4, m2: 8'hE6},
        '{m0: 8'hC5, m1: 8'h65, m2: 8'h9B},
        '{m0: 8'hA2, m1: 8'h79, m2: 8'h3D}
    };

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCK   = 2'd2
    } am_lock_state_e;

    // Lane constants are distinct, so at most one bit of a match vector is set.
    function automatic logic [1:0] lane_enc(input logic [LANE_N-1:0] match);
        logic [1:0] id;
        id = 2'd0;
        for (int l = 0; l < LANE_N; l++) begin
            if (match[l]) id = 2'(l);
        end
        return id;
    endfunction

endpackage

// File: rtl/pcs_40g_rx_am_lock_if.sv
// Per-lane 66b block stream into the AM lock block and its flagged output stream.
interface pcs_40g_rx_am_lock_if;

    logic        block_lock_i;
    logic        valid_i;
    logic [1:0]  head_i;
    logic [63:0] data_i;

    logic        valid_o;
    logic [1:0]  head_o;
    logic [63:0] data_o;
    logic        am_v_o;
    logic        am_lock_o;
    logic [1:0]  lane_o;
    logic        am_err_o;

    modport slave (
        input  block_lock_i, valid_i, head_i, data_i,
        output valid_o, head_o, data_o, am_v_o, am_lock_o, lane_o, am_err_o
    );

    modport master (
        output block_lock_i, valid_i, head_i, data_i,
        input  valid_o, head_o, data_o, am_v_o, am_lock_o, lane_o, am_err_o
    );

endinterface

// File: rtl/pcs_40g_rx_am_lock_am_lane_match.sv
// Combinational AM detector: one match bit per lane; BIP3/BIP7 bytes do not take part.
module am_lane_match
    import pcs_40g_pkg::*;
(
    input  logic [1:0]        i_head,
    input  logic [63:0]       i_data,
    output logic [LANE_N-1:0] o_match
);

    logic w_unused_bip;
    assign w_unused_bip = ^{i_data[63:56], i_data[31:24]};

    always_comb begin
        o_match = '0;
        for (int l = 0; l < LANE_N; l++) begin
            o_match[l] = (i_head == AM_SYNC)
                && (i_data[7:0]   ==  AM_LANE[l].m0)
                && (i_data[15:8]  ==  AM_LANE[l].m1)
                && (i_data[23:16] ==  AM_LANE[l].m2)
                && (i_data[39:32] == ~AM_LANE[l].m0)
                && (i_data[47:40] == ~AM_LANE[l].m1)
                && (i_data[55:48] == ~AM_LANE[l].m2);
        end
    end

endmodule

// File: rtl/pcs_40g_rx_am_lock.sv
// Per-lane RX alignment-marker lock: finds a marker, confirms its period,
// then flags marker blocks and tracks lock loss. All outputs are registered.
module pcs_40g_rx_am_lock
    import pcs_40g_pkg::*;
#(
    parameter int GAP_N   = 16383,
    parameter int INVLD_N = 4,
    parameter int CNT_W   = $clog2(GAP_N + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    pcs_40g_rx_am_lock_if.slave  io_bus
);

    localparam int INV_W = $clog2(INVLD_N + 1);

    am_lock_state_e    r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [INV_W-1:0]  r_inv, w_inv_nxt;
    logic [1:0]        r_lane, w_lane_nxt;
    logic [LANE_N-1:0] w_match;
    logic              w_slot, w_hit, w_am_v, w_am_err;

    logic              r_valid, r_am_v, r_am_lock, r_am_err;
    logic [1:0]        r_head, r_lane_o;
    logic [63:0]       r_data;

    function automatic logic [INV_W-1:0] inv_sat_inc(input logic [INV_W-1:0] v);
        return (v == {INV_W{1'b1}}) ? v : v + INV_W'(1);
    endfunction

    am_lane_match u_match (
        .i_head  (io_bus.head_i),
        .i_data  (io_bus.data_i),
        .o_match (w_match)
    );

    assign w_slot = (r_cnt == CNT_W'(GAP_N));
    assign w_hit  = w_match[r_lane];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SEARCH;
            r_cnt   <= '0;
            r_inv   <= '0;
            r_lane  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_inv   <= w_inv_nxt;
            r_lane  <= w_lane_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_inv_nxt   = r_inv;
        w_lane_nxt  = r_lane;
        w_am_v      = 1'b0;
        w_am_err    = 1'b0;
        if (!io_bus.block_lock_i) begin
            w_state_nxt = SEARCH;
            w_cnt_nxt   = '0;
            w_inv_nxt   = '0;
        end else if (io_bus.valid_i) begin
            case (r_state)
                SEARCH: begin
                    if (|w_match) begin
                        w_lane_nxt  = lane_enc(w_match);
                        w_cnt_nxt   = '0;
                        w_state_nxt = CHECK;
                    end
                end
                CHECK: begin
                    if (w_slot) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = w_hit ? LOCK : SEARCH;
                        w_inv_nxt   = '0;
                        w_am_v      = w_hit;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                LOCK: begin
                    if (w_slot) begin
                        w_cnt_nxt = '0;
                        if (w_hit) begin
                            w_am_v    = 1'b1;
                            w_inv_nxt = '0;
                        end else begin
                            w_am_err = 1'b1;
                            // This bad marker is the INVLD_N-th in a row: give up lock.
                            if (r_inv >= INV_W'(INVLD_N - 1)) begin
                                w_state_nxt = SEARCH;
                                w_inv_nxt   = '0;
                            end else begin
                                w_inv_nxt = inv_sat_inc(r_inv);
                            end
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = SEARCH;
                    w_cnt_nxt   = '0;
                    w_inv_nxt   = '0;
                end
            endcase
        end
    end

    // Output stage: flags describe the block being registered alongside them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_head    <= 2'd0;
            r_data    <= 64'd0;
            r_am_v    <= 1'b0;
            r_am_err  <= 1'b0;
            r_am_lock <= 1'b0;
            r_lane_o  <= 2'd0;
        end else begin
            r_valid   <= io_bus.valid_i;
            r_head    <= io_bus.head_i;
            r_data    <= io_bus.data_i;
            r_am_v    <= w_am_v;
            r_am_err  <= w_am_err;
            r_am_lock <= (w_state_nxt == LOCK);
            r_lane_o  <= (w_state_nxt == LOCK) ? w_lane_nxt : 2'd0;
        end
    end

    assign io_bus.valid_o   = r_valid;
    assign io_bus.head_o    = r_head;
    assign io_bus.data_o    = r_data;
    assign io_bus.am_v_o    = r_am_v;
    assign io_bus.am_err_o  = r_am_err;
    assign io_bus.am_lock_o = r_am_lock;
    assign io_bus.lane_o    = r_lane_o;

endmodule

// File: tb/tb_pcs_40g_rx_am_lock.sv
// Randomized bench for pcs_40g_rx_am_lock with a distance-based marker lock model
// compared every cycle, plus literal expectations at key points.
module tb_pcs_40g_rx_am_lock;

    localparam int GAP_N   = 15;
    localparam int INVLD_N = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pcs_40g_rx_am_lock_if io ();

    pcs_40g_rx_am_lock #(.GAP_N(GAP_N), .INVLD_N(INVLD_N)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (io)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;
    bit gaps    = 1'b0;

    logic [7:0] am_tab [4][3] = '{
        '{8'h90, 8'h76, 8'h47},
        '{8'hF0, 8'hC4, 8'hE6},
        '{8'hC5, 8'h65, 8'h9B},
        '{8'hA2, 8'h79, 8'h3D}
    };

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic int lane_of(input logic [1:0] h, input logic [63:0] d);
        bit ok;
        if (h != 2'b10) return -1;
        for (int l = 0; l < 4; l++) begin
            ok = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (d[8*k +: 8] != am_tab[l][k]) ok = 1'b0;
                if (d[8*(k+4) +: 8] != ~am_tab[l][k]) ok = 1'b0;
            end
            if (ok) return l;
        end
        return -1;
    endfunction

    function automatic logic [63:0] am_blk(input int l);
        return {8'($urandom), ~am_tab[l][2], ~am_tab[l][1], ~am_tab[l][0],
                8'($urandom), am_tab[l][2], am_tab[l][1], am_tab[l][0]};
    endfunction

    function automatic logic [63:0] corrupt(input logic [63:0] d);
        int p = $urandom_range(0, 47);
        if (p >= 24) p += 8;
        return d ^ (64'd1 << p);
    endfunction

    // Reference model: lock is tracked as distance in valid blocks since the anchor marker.
    bit          m_locked = 1'b0;
    int          m_lane   = -1;
    int          m_since  = 0;
    int          m_bad    = 0;
    logic        e_valid = 1'b0, e_am_v = 1'b0, e_err = 1'b0, e_lock = 1'b0;
    logic [1:0]  e_head = 2'd0, e_lane = 2'd0;
    logic [63:0] e_data = 64'd0;

    initial begin : model
        int hit;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_locked = 1'b0; m_lane = -1; m_since = 0; m_bad = 0;
                e_valid = 1'b0; e_head = 2'd0; e_data = 64'd0;
                e_am_v = 1'b0; e_err = 1'b0; e_lock = 1'b0; e_lane = 2'd0;
            end else begin
                e_valid = io.valid_i; e_head = io.head_i; e_data = io.data_i;
                e_am_v = 1'b0; e_err = 1'b0;
                if (!io.block_lock_i) begin
                    m_locked = 1'b0; m_lane = -1; m_since = 0; m_bad = 0;
                end else if (io.valid_i) begin
                    hit = lane_of(io.head_i, io.data_i);
                    if (m_lane < 0) begin
                        if (hit >= 0) begin m_lane = hit; m_since = 0; end
                    end else begin
                        m_since++;
                        if (m_since == GAP_N + 1) begin
                            m_since = 0;
                            if (hit == m_lane) begin
                                m_locked = 1'b1; m_bad = 0; e_am_v = 1'b1;
                            end else if (!m_locked) begin
                                m_lane = -1;
                            end else begin
                                e_err = 1'b1;
                                m_bad++;
                                if (m_bad == INVLD_N) begin
                                    m_locked = 1'b0; m_lane = -1; m_bad = 0;
                                end
                            end
                        end
                    end
                end
                e_lock = m_locked;
                e_lane = m_locked ? 2'(m_lane) : 2'd0;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("valid_o",   io.valid_o,   e_valid);
                chk("head_o",    io.head_o,    e_head);
                chk("data_o",    io.data_o,    e_data);
                chk("am_v_o",    io.am_v_o,    e_am_v);
                chk("am_err_o",  io.am_err_o,  e_err);
                chk("am_lock_o", io.am_lock_o, e_lock);
                chk("lane_o",    io.lane_o,    e_lane);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: bench still running, expected to finish");
        $fatal(1);
    end

    task automatic drive(input logic [1:0] h, input logic [63:0] d);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                io.valid_i = 1'b0;
                io.head_i  = 2'($urandom);
                io.data_i  = {$urandom, $urandom};
            end
        end
        @(negedge clk);
        io.valid_i = 1'b1;
        io.head_i  = h;
        io.data_i  = d;
    endtask

    task automatic idle();
        drive(($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10, {$urandom, $urandom});
    endtask

    task automatic idles(input int n);
        repeat (n) idle();
    endtask

    // kind: 0 good AM, 1 corrupted AM, 2 AM of another lane, 3 plain block at the slot
    task automatic period(input int kind, input int lane, input bit misplace);
        for (int i = 1; i <= GAP_N; i++) begin
            if (misplace && i == 7) drive(2'b10, am_blk($urandom_range(0, 3)));
            else idle();
        end
        case (kind)
            0:       drive(2'b10, am_blk(lane));
            1:       drive(2'b10, corrupt(am_blk(lane)));
            2:       drive(2'b10, am_blk((lane + $urandom_range(1, 3)) % 4));
            default: idle();
        endcase
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        io.block_lock_i = 1'b1;
        io.valid_i      = 1'b0;
        io.head_i       = 2'd0;
        io.data_i       = 64'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        settle();
        chk("rst_lock", io.am_lock_o, 0);
        chk("rst_lane", io.lane_o, 0);
        chk("rst_am_v", io.am_v_o, 0);

        // SEARCH -> CHECK -> LOCK on lane 2
        drive(2'b10, am_blk(2));
        settle();
        chk("t1_first_lock", io.am_lock_o, 0);
        chk("t1_first_am_v", io.am_v_o, 0);
        period(0, 2, 1'b0);
        settle();
        chk("t1_lock", io.am_lock_o, 1);
        chk("t1_lane", io.lane_o, 2);
        chk("t1_am_v", io.am_v_o, 1);

        // three bad markers keep lock, a good one clears the bad count
        for (int i = 0; i < 3; i++) begin
            period((i == 1) ? 2 : 1, 2, 1'b0);
            settle();
            chk("t2_err", io.am_err_o, 1);
            chk("t2_hold", io.am_lock_o, 1);
        end
        period(0, 2, 1'b0);
        settle();
        chk("t2_good_am_v", io.am_v_o, 1);
        chk("t2_good_err", io.am_err_o, 0);
        for (int i = 0; i < 3; i++) period(1, 2, 1'b0);
        period(3, 2, 1'b0);
        settle();
        chk("t2_loss_err", io.am_err_o, 1);
        chk("t2_loss_lock", io.am_lock_o, 0);

        // CHECK failure on a different lane; that block does not restart CHECK
        drive(2'b10, am_blk(1));
        idles(GAP_N);
        drive(2'b10, am_blk(3));
        settle();
        chk("t3_fail_lock", io.am_lock_o, 0);
        chk("t3_fail_am_v", io.am_v_o, 0);
        idles(GAP_N);
        drive(2'b10, am_blk(3));
        settle();
        chk("t3_restart_lock", io.am_lock_o, 0);
        period(0, 3, 1'b0);
        settle();
        chk("t3_lock", io.am_lock_o, 1);
        chk("t3_lane", io.lane_o, 3);

        // valid gaps and misplaced markers
        gaps = 1'b1;
        repeat (6) period(0, 3, 1'b1);
        settle();
        chk("t4_lock", io.am_lock_o, 1);
        chk("t4_am_v", io.am_v_o, 1);

        // block lock drop for one cycle
        @(negedge clk);
        io.block_lock_i = 1'b0;
        io.valid_i      = 1'b1;
        io.head_i       = 2'b01;
        io.data_i       = {$urandom, $urandom};
        settle();
        chk("t5_drop_lock", io.am_lock_o, 0);
        @(negedge clk);
        io.block_lock_i = 1'b1;
        io.valid_i      = 1'b0;
        drive(2'b10, am_blk(0));
        settle();
        chk("t5_one_am_lock", io.am_lock_o, 0);
        period(0, 0, 1'b0);
        settle();
        chk("t5_relock", io.am_lock_o, 1);
        chk("t5_lane", io.lane_o, 0);

        // asynchronous reset in the middle of CHECK
        drive(2'b10, am_blk(1));
        idles(5);
        settle();
        chk("t6_pre_valid", io.valid_o, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", io.valid_o, 0);
        chk("t6_rst_data", io.data_o, 0);
        chk("t6_rst_head", io.head_o, 0);
        chk("t6_rst_lock", io.am_lock_o, 0);
        @(negedge clk);
        rst = 1'b0;
        io.valid_i = 1'b0;
        drive(2'b10, am_blk(1));
        settle();
        chk("t6_search_lock", io.am_lock_o, 0);
        period(0, 1, 1'b0);
        settle();
        chk("t6_relock", io.am_lock_o, 1);
        chk("t6_lane", io.lane_o, 1);

        // random mix of good and bad markers, gaps and misplaced patterns
        repeat (12) begin
            int k;
            k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            period(k, 1, 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        io.valid_i = 1'b0;
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pcs_40g_rx_am_lock.md
Name: pcs_40g_rx_am_lock

Overview:
- Receive-side counterpart of the 40GBASE-R transmit alignment-marker inserter; one instance per physical lane.
- Sits after per-lane 64b/66b block lock and before lane deskew/reorder.
- Searches for any of the 4 lane alignment markers (AM), confirms the marker period, then reports lock and the logical lane id.
- Flags marker blocks so downstream logic strips them, and detects loss of marker lock.

Parameters:
- GAP_N, 16383, data blocks between consecutive AMs; the AM period is GAP_N+1 blocks. Benches use 15.
- INVLD_N, 4, consecutive bad AMs while locked that force loss of lock.
- CNT_W, $clog2(GAP_N+1), width of the gap counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- block_lock_i  in  1  upstream 66b block lock for this lane
- valid_i  in  1  one 66b block present this cycle
- head_i  in  2  sync header; 2'b10 = control block
- data_i  in  64  block payload; M0 in [7:0], BIP7 in [63:56]
- valid_o  out  1  registered valid_i
- head_o  out  2  registered head_i
- data_o  out  64  registered data_i
- am_v_o  out  1  current output block is an accepted AM
- am_lock_o  out  1  alignment marker lock
- lane_o  out  2  logical lane id of the locked marker
- am_err_o  out  1  one-cycle pulse: expected AM mismatched while locked

Behaviour:
- Reset values: all outputs 0, state SEARCH, counters 0, lane register 0.
- Latency: every output is registered with 1 cycle latency. am_v_o, am_err_o, am_lock_o and lane_o are aligned with the block they describe on data_o.
- AM match: head_i==2'b10, bytes M0,M1,M2 equal the lane constants, and M4,M5,M6 equal their bitwise inverses. BIP3 [31:24] and BIP7 [63:56] are ignored.
- Lane constants (M0,M1,M2):
  - lane0: 0x90,0x76,0x47
  - lane1: 0xF0,0xC4,0xE6
  - lane2: 0xC5,0x65,0x9B
  - lane3: 0xA2,0x79,0x3D
- Only cycles with valid_i=1 are evaluated or advance counters. A valid_i=0 cycle holds all state.
- SEARCH:
  - Any valid block matching any lane: store lane id, cnt=0, go to CHECK.
  - am_v_o stays 0.
- CHECK:
  - Each valid block: cnt++.
  - When cnt==GAP_N, the next valid block is the expected AM.
  - Match on the stored lane: go to LOCK, am_lock_o=1, lane_o=stored id, am_v_o=1 for that block, cnt=0, inv_cnt=0.
  - Otherwise (no match or a different lane): go to SEARCH. That block is not re-examined as a new first marker.
- LOCK:
  - cnt counts from 0 to GAP_N and wraps to 0 on the expected AM slot.
  - Good AM: am_v_o=1, inv_cnt=0.
  - Bad AM: am_err_o=1, am_v_o=0, inv_cnt++.
  - When inv_cnt reaches INVLD_N: go to SEARCH and drop am_lock_o on that same output cycle.
  - A valid AM for a different lane counts as bad.
  - An AM pattern at an unexpected position is ignored.
- block_lock_i=0, in any state and with priority over everything else: next state SEARCH, counters cleared, am_lock_o=0, no am_v_o/am_err_o.
- Data pass-through continues regardless of lock state. Marker blocks are flagged, never dropped.
- rst mid-operation: asynchronous return to reset values. No partial output survives.
- Counter arithmetic is unsigned CNT_W bits. inv_cnt is $clog2(INVLD_N+1) bits and saturates.

Decomposition:
- pcs_40g_pkg holds:
  - LANE_N=4
  - AM constant array am_lane_t[LANE_N] of {M0,M1,M2}
  - AM_SYNC=2'b10
  - state enum am_lock_state_e {SEARCH, CHECK, LOCK}
- The transmit marker inserter reuses the same constants.
- Sub-module am_lane_match: combinational, data_i/head_i in, 4-bit match vector out. The block instantiates it once.

Test Plan:
- SEARCH to LOCK: GAP_N=15, block_lock_i=1, lane2 AM, 15 idle blocks, lane2 AM.
  - am_lock_o rises 1 cycle after the 2nd AM; lane_o=2; am_v_o=1 on that block only.
- CHECK failure: lane1 AM, 15 idles, lane3 AM.
  - Stays unlocked, returns to SEARCH. A lane3 AM 16 blocks later only restarts CHECK.
- Lock loss: in LOCK, corrupt 3 expected AMs then send a good one.
  - 3 am_err_o pulses, lock held, inv_cnt reset.
  - Then corrupt 4 in a row: am_lock_o falls with the 4th am_err_o.
- valid_i gaps: insert random valid_i=0 cycles between blocks.
  - Lock and AM positions are unchanged.
  - The misplaced AM pattern at block 7 is ignored.
- block_lock_i drop: deassert for 1 cycle while locked.
  - am_lock_o=0 next cycle. Relock requires two AMs.
- Async rst mid-CHECK.
  - All outputs 0 immediately, before the next clk edge. Resumes in SEARCH.
